// File: rtl/sum_numbers_pkg.sv
// Shared types and default widths for the sum_numbers arithmetic-series engine.
package sum_numbers_pkg;

   localparam int unsigned DEF_N_W   = 4;
   localparam int unsigned DEF_SUM_W = 7;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      ACC  = 2'd1,
      HOLD = 2'd2
   } state_t;

endpackage : sum_numbers_pkg

// File: rtl/sum_numbers_if.sv
// Bus bundle between the series engine and its producer/consumer.
interface sum_numbers_if
   import sum_numbers_pkg::*;
#(
   parameter int unsigned N_W   = DEF_N_W,
   parameter int unsigned SUM_W = DEF_SUM_W
);

   logic [N_W-1:0]   N;
   logic [SUM_W-1:0] rout;
   logic [SUM_W-1:0] temp;
   logic             done;

   modport master (output N, input rout, input temp, input done);
   modport slave  (input N, output rout, output temp, output done);

endinterface : sum_numbers_if

// File: rtl/sum_numbers.sv
// Computes 1 + 2 + ... + N with one adder, one addend per clock; restarts when N changes
// after a completed result.
module sum_numbers
   import sum_numbers_pkg::*;
#(
   parameter int unsigned N_W   = DEF_N_W,
   parameter int unsigned SUM_W = DEF_SUM_W
) (
   input  logic          clk,
   input  logic          rst_n,
   sum_numbers_if.slave  io_bus
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [N_W-1:0]   r_n_lat;
   logic [N_W-1:0]   r_cnt;
   logic [SUM_W-1:0] r_temp;
   logic [SUM_W-1:0] r_rout;
   logic             r_done;
   logic             w_last;
   logic [SUM_W-1:0] w_sum;

   assign w_last = (r_cnt == r_n_lat);
   // The single adder: next partial sum adds the upcoming addend cnt+1.
   assign w_sum  = r_temp + SUM_W'(r_cnt) + SUM_W'(1);

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         LOAD:    w_state_nxt = ACC;
         ACC:     if (w_last) w_state_nxt = HOLD;
         HOLD:    if (io_bus.N != r_n_lat) w_state_nxt = LOAD;
         default: w_state_nxt = LOAD;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= LOAD;
      else        r_state <= w_state_nxt;
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_n_lat <= '0;
         r_cnt   <= '0;
         r_temp  <= '0;
         r_rout  <= '0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            LOAD: begin
               r_n_lat <= io_bus.N;
               r_cnt   <= '0;
               r_temp  <= '0;
               r_done  <= 1'b0;
            end
            ACC: begin
               if (!w_last) begin
                  r_cnt  <= r_cnt + N_W'(1);
                  r_temp <= w_sum;
               end else begin
                  r_rout <= r_temp;
                  r_done <= 1'b1;
               end
            end
            HOLD:    r_done <= 1'b0;
            default: r_done <= 1'b0;
         endcase
      end
   end

   assign io_bus.rout = r_rout;
   assign io_bus.temp = r_temp;
   assign io_bus.done = r_done;

endmodule : sum_numbers

// File: tb/tb_sum_numbers.sv
// Directed self-checking bench for sum_numbers with a result scoreboard.
module tb_sum_numbers;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;
   int   exp_q[$];

   sum_numbers_if #(.N_W(4), .SUM_W(7)) bus ();

   sum_numbers #(.N_W(4), .SUM_W(7)) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and sample just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_n(input int n);
      bus.N = 4'(n);
      exp_q.push_back(n * (n + 1) / 2);
   endtask

   // Entered right after the LOAD edge; walks the ACC edges and the done pulse.
   task automatic run_series(input int n, input int prev_rout);
      int exp_r;
      for (int k = 1; k <= n; k++) begin
         step();
         check($sformatf("temp_k%0d_n%0d", k, n), 32'(bus.temp), k * (k + 1) / 2);
         check($sformatf("done_low_k%0d", k), 32'(bus.done), 0);
         check($sformatf("rout_hold_k%0d", k), 32'(bus.rout), prev_rout);
      end
      step();
      if (exp_q.size() != 0) exp_r = exp_q.pop_front();
      else                   exp_r = -1;
      check($sformatf("done_pulse_n%0d", n), 32'(bus.done), 1);
      check($sformatf("rout_n%0d", n), 32'(bus.rout), exp_r);
      check($sformatf("temp_final_n%0d", n), 32'(bus.temp), n * (n + 1) / 2);
      step();
      check($sformatf("done_clear_n%0d", n), 32'(bus.done), 0);
      check($sformatf("rout_keep_n%0d", n), 32'(bus.rout), exp_r);
   endtask

   // From HOLD: apply new N, pass the HOLD edge and the LOAD edge, then run.
   task automatic apply_new_n(input int n, input int prev_rout);
      drive_n(n);
      step();
      check("hold_edge_rout", 32'(bus.rout), prev_rout);
      check("hold_edge_done", 32'(bus.done), 0);
      step();
      check("load_temp", 32'(bus.temp), 0);
      run_series(n, prev_rout);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.N = 4'd0;

      // Reset held with N=2
      drive_n(2);
      repeat (3) step();
      check("rst_rout", 32'(bus.rout), 0);
      check("rst_temp", 32'(bus.temp), 0);
      check("rst_done", 32'(bus.done), 0);

      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("n2_load_temp", 32'(bus.temp), 0);
      run_series(2, 0);

      // Worst case and zero bound
      apply_new_n(15, 3);
      apply_new_n(0, 120);

      // N changes mid-ACC are ignored until HOLD
      drive_n(2);
      step();
      step();
      check("chg_load_temp", 32'(bus.temp), 0);
      step();
      check("chg_temp1", 32'(bus.temp), 1);
      drive_n(4);
      step();
      check("chg_temp3", 32'(bus.temp), 3);
      step();
      check("chg_done", 32'(bus.done), 1);
      check("chg_first_rout", 32'(bus.rout), (exp_q.size() != 0) ? exp_q.pop_front() : -1);
      step();
      check("chg_hold_done", 32'(bus.done), 0);
      check("chg_hold_rout", 32'(bus.rout), 3);
      step();
      check("chg_reload_temp", 32'(bus.temp), 0);
      run_series(4, 3);

      // Reset asserted mid-ACC with N=15
      drive_n(15);
      step();
      step();
      repeat (6) step();
      check("mid_temp21", 32'(bus.temp), 21);
      rst_n = 1'b0;
      #1;
      check("async_rout", 32'(bus.rout), 0);
      check("async_temp", 32'(bus.temp), 0);
      check("async_done", 32'(bus.done), 0);
      repeat (2) step();
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("rerun_load_temp", 32'(bus.temp), 0);
      run_series(15, 0);

      check("scoreboard_empty", 32'(exp_q.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_sum_numbers
